// File: rtl/instruction_fetcher.sv
// Fetch stage: holds the PC and a direct-mapped one-word-per-line instruction cache.
// Hits push one instruction per cycle; misses run a single-word refill through memory.
//
// state   | meaning
// S_FETCH | look up pc; emit on hit, start a refill on miss, redirect on flush
// S_WAIT  | refill outstanding; mem_req/mem_addr held until mem_done
module instruction_fetcher #(
  parameter int          ICACHE_ENTRIES = 16,
  parameter logic [31:0] RESET_PC       = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        iq_full,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc
);

  localparam int IDX  = $clog2(ICACHE_ENTRIES);
  localparam int TAGW = 30 - IDX;

  typedef enum logic {S_FETCH, S_WAIT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        mem_req_nxt;
  logic [31:0] mem_addr_nxt;
  logic        inst_valid_nxt;
  logic [31:0] inst_out_nxt;
  logic [31:0] inst_pc_nxt;

  logic [ICACHE_ENTRIES-1:0] line_valid;
  logic [TAGW-1:0]           line_tag  [ICACHE_ENTRIES];
  logic [31:0]               line_data [ICACHE_ENTRIES];

  logic [IDX-1:0]  pc_idx, fill_idx;
  logic [TAGW-1:0] pc_tag, fill_tag;
  logic [31:0]     redirect_pc;
  logic            hit;
  logic            fill_en;

  assign pc_idx      = pc[IDX+1:2];
  assign pc_tag      = pc[31:IDX+2];
  // The fill lands where the request was made, not where the pc points after a flush.
  assign fill_idx    = mem_addr[IDX+1:2];
  assign fill_tag    = mem_addr[31:IDX+2];
  assign redirect_pc = flush_pc & 32'hFFFF_FFFC;
  assign hit         = line_valid[pc_idx] && (line_tag[pc_idx] == pc_tag);

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    mem_req_nxt    = mem_req;
    mem_addr_nxt   = mem_addr;
    inst_valid_nxt = 1'b0;
    inst_out_nxt   = inst_out;
    inst_pc_nxt    = inst_pc;
    fill_en        = 1'b0;
    case (state)
      S_FETCH: begin
        if (flush) begin
          pc_nxt = redirect_pc;
        end else if (!iq_full) begin
          if (hit) begin
            inst_valid_nxt = 1'b1;
            inst_out_nxt   = line_data[pc_idx];
            inst_pc_nxt    = pc;
            pc_nxt         = pc + 32'd4;
          end else begin
            mem_req_nxt  = 1'b1;
            mem_addr_nxt = pc;
            state_nxt    = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (flush) begin
          pc_nxt = redirect_pc;
        end
        if (mem_done) begin
          fill_en     = 1'b1;
          mem_req_nxt = 1'b0;
          state_nxt   = S_FETCH;
        end
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      mem_req    <= 1'b0;
      mem_addr   <= 32'h0;
      inst_valid <= 1'b0;
      inst_out   <= 32'h0;
      inst_pc    <= 32'h0;
      line_valid <= '0;
    end else if (rdy_in) begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      mem_req    <= mem_req_nxt;
      mem_addr   <= mem_addr_nxt;
      inst_valid <= inst_valid_nxt;
      inst_out   <= inst_out_nxt;
      inst_pc    <= inst_pc_nxt;
      if (fill_en) begin
        line_valid[fill_idx] <= 1'b1;
      end
    end
  end

  // Tag/data storage needs no reset: a line is only read once its valid bit is set.
  always_ff @(posedge clk_in) begin
    if (rdy_in && fill_en) begin
      line_tag[fill_idx]  <= fill_tag;
      line_data[fill_idx] <= mem_data;
    end
  end

endmodule

// File: tb/tb_instruction_fetcher.sv
// Self-checking bench for instruction_fetcher: a scoreboard of expected fetch PCs,
// a small memory responder and directed phases for stalls, flushes, pauses and reset.
module tb_instruction_fetcher;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        iq_full;
  logic        flush;
  logic [31:0] flush_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done = 1'b0;
  logic [31:0] mem_data = 32'h0;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;

  logic        rdy_seen = 1'b0;
  logic        mem_auto = 1'b0;
  logic        found;
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] sb[$];

  instruction_fetcher #(.ICACHE_ENTRIES(16), .RESET_PC(32'h0)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .iq_full   (iq_full),
    .flush     (flush),
    .flush_pc  (flush_pc),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_done  (mem_done),
    .mem_data  (mem_data),
    .inst_valid(inst_valid),
    .inst_out  (inst_out),
    .inst_pc   (inst_pc)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00500093;
    return (a * 32'h9E3779B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
    #1;
  endtask

  task automatic push_run(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) sb.push_back(first + 32'(4 * i));
  endtask

  // Lets the responder fire mem_done at the next negedge; returns with mem_done pending.
  task automatic mem_pulse();
    mem_auto = 1'b1;
    tick();
    mem_auto = 1'b0;
  endtask

  task automatic run_hits(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(tag, 32'(inst_valid), 32'd1);
      chk({tag, "_noreq"}, 32'(mem_req), 32'd0);
    end
  endtask

  always @(posedge clk_in) rdy_seen <= rdy_in;

  // Memory controller: pauses with rdy_in, holds mem_done until a ready edge takes it.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      mem_done = 1'b0;
    end else if (mem_done) begin
      if (rdy_seen) mem_done = 1'b0;
    end else if (mem_auto && mem_req && rdy_seen) begin
      mem_done = 1'b1;
      mem_data = mem_word(mem_addr);
    end
  end

  // Each push accepted by the queue is popped against the scoreboard.
  always @(negedge clk_in) begin
    logic [31:0] exp_pc;
    if (rst_in && rdy_seen && inst_valid) begin
      exp_pc = (sb.size() != 0) ? sb.pop_front() : 32'hDEAD_BEEF;
      chk("emit_pc", inst_pc, exp_pc);
      chk("emit_data", inst_out, mem_word(exp_pc));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_in   = 1'b1;
    rdy_in   = 1'b1;
    iq_full  = 1'b0;
    flush    = 1'b0;
    flush_pc = 32'h0;
    #1 rst_in = 1'b0;
    #2;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst_out", inst_out, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);

    // cold miss at pc 0, refill bubble, emit, next miss
    tick();
    rst_in   = 1'b1;
    mem_auto = 1'b1;
    sb.push_back(32'h0);
    tick();
    chk("p1_req", 32'(mem_req), 32'd1);
    chk("p1_addr", mem_addr, 32'h0);
    tick();
    chk("p1_bubble_valid", 32'(inst_valid), 32'd0);
    chk("p1_bubble_req", 32'(mem_req), 32'd0);
    tick();
    chk("p1_emit_valid", 32'(inst_valid), 32'd1);
    chk("p1_emit_data", inst_out, 32'h00500093);
    chk("p1_emit_pc", inst_pc, 32'h0);
    tick();
    chk("p1_req2", 32'(mem_req), 32'd1);
    chk("p1_addr2", mem_addr, 32'h4);
    push_run(32'h4, 15);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (inst_valid && inst_pc == 32'h3C) found = 1'b1;
    end
    chk("p1_stream_done", 32'(found), 32'd1);

    // loop back to 0: sixteen back-to-back hits
    mem_auto = 1'b0;
    flush    = 1'b1;
    flush_pc = 32'h0;
    push_run(32'h0, 16);
    tick();
    flush = 1'b0;
    chk("p2_flush_noemit", 32'(inst_valid), 32'd0);
    chk("p2_flush_noreq", 32'(mem_req), 32'd0);
    run_hits("p2_hit", 16);

    // iq_full stall mid-stream; flush_pc low bits ignored
    flush    = 1'b1;
    flush_pc = 32'h3;
    tick();
    flush = 1'b0;
    chk("p3_flush_noemit", 32'(inst_valid), 32'd0);
    push_run(32'h0, 3);
    run_hits("p3_pre", 3);
    iq_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("p3_stall_valid", 32'(inst_valid), 32'd0);
      chk("p3_stall_req", 32'(mem_req), 32'd0);
    end
    iq_full = 1'b0;
    push_run(32'hC, 12);
    run_hits("p3_post", 12);

    // flush beats a hit at 0x3C
    flush    = 1'b1;
    flush_pc = 32'h20;
    tick();
    flush = 1'b0;
    chk("p5_flush_hit_valid", 32'(inst_valid), 32'd0);
    chk("p5_flush_hit_req", 32'(mem_req), 32'd0);
    push_run(32'h20, 8);
    run_hits("p5_redir", 8);

    // miss at 0x40, flush to 0x100 while outstanding
    tick();
    chk("p4_req", 32'(mem_req), 32'd1);
    chk("p4_addr", mem_addr, 32'h40);
    flush    = 1'b1;
    flush_pc = 32'h100;
    for (int i = 0; i < 3; i++) begin
      tick();
      flush = 1'b0;
      chk("p4_hold_req", 32'(mem_req), 32'd1);
      chk("p4_hold_addr", mem_addr, 32'h40);
      chk("p4_hold_valid", 32'(inst_valid), 32'd0);
    end
    mem_pulse();
    chk("p4_addr_at_done", mem_addr, 32'h40);
    tick();
    chk("p4_fill_req", 32'(mem_req), 32'd0);
    chk("p4_fill_valid", 32'(inst_valid), 32'd0);
    tick();
    chk("p4_newreq", 32'(mem_req), 32'd1);
    chk("p4_newaddr", mem_addr, 32'h100);

    // mem_done and flush together: fill 0x100, redirect to 0x4
    mem_pulse();
    flush    = 1'b1;
    flush_pc = 32'h4;
    push_run(32'h4, 15);
    tick();
    flush = 1'b0;
    chk("p5_done_flush_req", 32'(mem_req), 32'd0);
    chk("p5_done_flush_valid", 32'(inst_valid), 32'd0);
    run_hits("p5_after", 3);

    // rdy_in low mid-stream: everything frozen, no double push
    rdy_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("p6_frozen_valid", 32'(inst_valid), 32'd1);
      chk("p6_frozen_pc", inst_pc, 32'hC);
      chk("p6_frozen_req", 32'(mem_req), 32'd0);
    end
    rdy_in = 1'b1;
    tick();
    chk("p6_resume_valid", 32'(inst_valid), 32'd1);
    chk("p6_resume_pc", inst_pc, 32'h10);
    run_hits("p6_stream", 11);

    // 0x100 must now hit from the fill done alongside the flush
    flush    = 1'b1;
    flush_pc = 32'h100;
    sb.push_back(32'h100);
    tick();
    flush = 1'b0;
    chk("p5_chk_noemit", 32'(inst_valid), 32'd0);
    tick();
    chk("p5_fill_hit_valid", 32'(inst_valid), 32'd1);
    chk("p5_fill_hit_pc", inst_pc, 32'h100);
    chk("p5_fill_hit_req", 32'(mem_req), 32'd0);
    tick();
    chk("p6_miss_req", 32'(mem_req), 32'd1);
    chk("p6_miss_addr", mem_addr, 32'h104);

    // rdy_in low in WAIT with mem_done pending: the pulse must survive the pause
    sb.push_back(32'h104);
    mem_pulse();
    rdy_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("p6_wait_req", 32'(mem_req), 32'd1);
      chk("p6_wait_addr", mem_addr, 32'h104);
      chk("p6_wait_valid", 32'(inst_valid), 32'd0);
    end
    rdy_in = 1'b1;
    tick();
    chk("p6_done_kept", 32'(mem_req), 32'd0);
    tick();
    chk("p6_emit_valid", 32'(inst_valid), 32'd1);
    tick();
    chk("p6_req_108", 32'(mem_req), 32'd1);
    chk("p6_addr_108", mem_addr, 32'h108);

    // async reset mid-WAIT, then the cache must be cold again
    rst_in = 1'b0;
    #1;
    chk("p6_rst_req", 32'(mem_req), 32'd0);
    chk("p6_rst_valid", 32'(inst_valid), 32'd0);
    chk("p6_rst_addr", mem_addr, 32'h0);
    tick();
    rst_in   = 1'b1;
    flush    = 1'b1;
    flush_pc = 32'h4;
    tick();
    flush = 1'b0;
    chk("p6_post_rst_req", 32'(mem_req), 32'd0);
    chk("p6_post_rst_valid", 32'(inst_valid), 32'd0);
    tick();
    chk("p6_inval_req", 32'(mem_req), 32'd1);
    chk("p6_inval_addr", mem_addr, 32'h4);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetcher.md
Name: instruction_fetcher

Overview:
Front-end stage directly upstream of instruction_queue. It holds the PC and a direct-mapped instruction cache. On a hit, it pushes one instruction per cycle into the queue. On a miss, it runs a single-word read through the memory controller. Redirects from branch resolution flush the fetch stream and reload the PC.

Parameters:
ICACHE_ENTRIES, 16, number of one-word cache lines (power of two, ≥2); IDX = log2(ICACHE_ENTRIES)
RESET_PC, 32'h0, PC value loaded on reset

Ports:
clk_in  input  1  system clock, rising edge
rst_in  input  1  reset, asynchronous, active-low
rdy_in  input  1  global ready; low = pause
iq_full  input  1  is_full from instruction_queue
flush  input  1  redirect request, one-cycle pulse
flush_pc  input  32  new fetch address accompanying flush
mem_req  output  1  read request to memory controller
mem_addr  output  32  word address of the request
mem_done  input  1  one-cycle pulse: mem_data valid
mem_data  input  32  returned instruction word
inst_valid  output  1  one-cycle push strobe to instruction_queue
inst_out  output  32  instruction word (drives instruction_in)
inst_pc  output  32  PC of inst_out

Behaviour:
- All outputs are registered.
- Reset (rst_in low, async):
  - pc=RESET_PC, state=FETCH, all cache valid bits=0.
  - mem_req=0, mem_addr=0, inst_valid=0, inst_out=0, inst_pc=0.
  - Reset mid-miss abandons the request; the memory controller is reset by the same signal.
- rdy_in low: no register changes at all, including inst_valid. The queue pauses on the same signal, so a held strobe is not double-counted.
- Cache addressing:
  - index=pc[IDX+1:2], tag=pc[31:IDX+2].
  - Each line is {valid, tag, data}.
  - pc[1:0] is always 0; flush_pc[1:0] is ignored (forced 0).
- Default each cycle: inst_valid<=0.
- State FETCH:
  - flush=1: pc<=flush_pc, no emit, stay FETCH. Flush wins over a hit.
  - else iq_full=1: hold pc, no emit.
  - else hit: inst_valid<=1, inst_out<=line data, inst_pc<=pc, pc<=pc+4 (32-bit wrap, 0xFFFFFFFC->0). Sustained rate is 1 instruction/cycle.
  - else miss: mem_req<=1, mem_addr<=pc, state<=WAIT.
- State WAIT:
  - mem_req and mem_addr are held stable until mem_done.
  - On mem_done: write line at mem_addr's index (valid=1, tag, data=mem_data), mem_req<=0, state<=FETCH. The instruction is not emitted directly; the next FETCH cycle hits, giving a 1-cycle refill bubble.
  - flush in WAIT: pc<=flush_pc, stay WAIT. The outstanding fill still completes into the cache, since it is valid for mem_addr. The next FETCH uses the new pc.
  - flush and mem_done in the same cycle: do both (fill, pc<=flush_pc, state<=FETCH).
- Latency:
  - Hit: pc present -> inst_valid next edge.
  - Miss: 1 cycle to raise mem_req, then memory latency, then 1 refill cycle, then emit on the following edge.
- Contract with instruction_queue: iq_full is sampled in the decision cycle. The queue must assert is_full when ≤1 free slot remains, so the registered push is always accepted.
- No self-modifying-code coherence; the cache is invalidated only by reset.

Test Plan:
1. Reset with RESET_PC=0; first FETCH misses -> mem_req=1, mem_addr=0 next cycle. mem_done with mem_data=32'h00500093 -> two cycles later inst_valid=1, inst_out=32'h00500093, inst_pc=0; then mem_req=1, mem_addr=4.
2. Prefill lines 0x0–0x3C, loop back to pc=0 via flush, flush_pc=0 -> 16 consecutive inst_valid pulses, inst_pc 0,4,…,0x3C, no mem_req.
3. Hit stream with iq_full high for 3 cycles mid-stream -> no inst_valid during those cycles, pc held, stream resumes at the next address with no skip or duplicate.
4. Miss at 0x40 outstanding, flush with flush_pc=0x100 before mem_done -> mem_addr stays 0x40 until mem_done, line 0 filled with tag for 0x40. The next request is mem_addr=0x100, and no instruction from 0x40 is emitted.
5. flush and a cache hit in the same cycle -> inst_valid=0 that edge, pc=flush_pc. flush together with mem_done -> fill and redirect both take effect.
6. rdy_in low for 4 cycles during a hit stream and during WAIT -> all outputs frozen. Operation resumes exactly where it stopped, and mem_done pulses are not lost (the controller is paused too). Asserting rst_in low mid-WAIT -> mem_req=0 and inst_valid=0 immediately.
